// File: rtl/sonar_pkg.sv
// Shared definitions for the ultrasonic sensor emulator and its controller.
// Holds the emulator state encoding, the default timing constants at 100 MHz,
// and the helper that turns the sampled range inputs into an echo length.
package sonar_pkg;

    // Emulator states, in the order a measurement walks through them.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_TRIG_HI = 3'd1,
        ST_BURST   = 3'd2,
        ST_ECHO    = 3'd3,
        ST_HOLDOFF = 3'd4
    } sonar_state_e;

    // Default timing at 100 MHz.
    localparam int unsigned SONAR_MIN_TRIG_CYC = 32'd1000;     // 10 us trigger
    localparam int unsigned SONAR_BURST_CYC    = 32'd20000;    // 200 us burst
    localparam int unsigned SONAR_TIMEOUT_CYC  = 32'd3800000;  // 38 ms no-object echo
    localparam int unsigned SONAR_HOLDOFF_CYC  = 32'd6000000;  // 60 ms dead time
    localparam int unsigned SONAR_CW           = 32'd24;

    // Echo high time: the requested length when an object is present,
    // otherwise the timeout; never longer than the timeout.
    function automatic int unsigned echo_cycles(input logic [15:0] len,
                                                input logic        obj,
                                                input int unsigned timeout);
        int unsigned l;
        l = obj ? {16'd0, len} : timeout;
        return (l > timeout) ? timeout : l;
    endfunction

endpackage

// File: rtl/sonar_cycle_timer.sv
// Load/decrement interval timer with a zero flag.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : load load_val this cycle (takes priority over counting)
//   load_val   : value to load; the interval lasts load_val+1 cycles to zero
//   zero       : high while the count is zero
// The count stops at zero, so it never wraps.
module sonar_cycle_timer #(
    parameter int unsigned CW = 24
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    output logic          zero
);

    localparam logic [CW-1:0] ONE = {{(CW-1){1'b0}}, 1'b1};

    logic [CW-1:0] count_r;

    // Count register: load, else decrement until zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= {CW{1'b0}};
        end else if (load) begin
            count_r <= load_val;
        end else if (count_r != {CW{1'b0}}) begin
            count_r <= count_r - ONE;
        end else begin
            count_r <= count_r;
        end
    end

    assign zero = (count_r == {CW{1'b0}});

endmodule

// File: rtl/sonar_echo_emulator.sv
// Ultrasonic sensor emulator: answers a trigger pulse with an echo pulse.
// Validates the trigger width, waits out the transmit burst, drives echo for
// the programmed time-of-flight (or the no-object timeout), then holds off.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   trig        : trigger from the controller (synchronous to clk)
//   echo_len    : echo width in cycles when an object is present
//   obj_present : 1 = use echo_len, 0 = timeout echo
//   echo        : echo pulse
//   busy        : high in every state except idle
//   trig_short  : one-cycle pulse when a too-short trigger is rejected
//   done        : one-cycle pulse when echo falls (or would have fallen)
module sonar_echo_emulator
    import sonar_pkg::*;
#(
    parameter int unsigned MIN_TRIG_CYC = SONAR_MIN_TRIG_CYC,
    parameter int unsigned BURST_CYC    = SONAR_BURST_CYC,
    parameter int unsigned TIMEOUT_CYC  = SONAR_TIMEOUT_CYC,
    parameter int unsigned HOLDOFF_CYC  = SONAR_HOLDOFF_CYC,
    parameter int unsigned CW           = SONAR_CW
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        trig,
    input  logic [15:0] echo_len,
    input  logic        obj_present,
    output logic        echo,
    output logic        busy,
    output logic        trig_short,
    output logic        done
);

    localparam logic [CW-1:0] ONE      = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] MIN_C    = CW'(MIN_TRIG_CYC);
    // Timer loads are one less than the interval: the timer reaches zero
    // on the interval's last edge.
    localparam logic [CW-1:0] BURST_LD = CW'(BURST_CYC - 32'd1);
    localparam logic [CW-1:0] HOLD_LD  = CW'(HOLDOFF_CYC - 32'd1);

    sonar_state_e  state_r;
    logic          trig_q_r;
    logic [CW-1:0] width_r;
    logic [CW-1:0] len_r;
    logic          echo_r;
    logic          busy_r;
    logic          trig_short_r;
    logic          done_r;

    logic          rise_s;
    logic          fall_s;
    logic          width_ok_s;
    logic [CW-1:0] len_s;
    logic          tmr_load_s;
    logic [CW-1:0] tmr_val_s;
    logic          tmr_zero_s;

    assign rise_s     = trig & ~trig_q_r;
    assign fall_s     = ~trig & trig_q_r;
    assign width_ok_s = (width_r >= MIN_C);
    assign len_s      = CW'(echo_cycles(echo_len, obj_present, TIMEOUT_CYC));

    // Timer load decode: each interval is armed on the edge that enters it.
    always_comb begin
        tmr_load_s = 1'b0;
        tmr_val_s  = {CW{1'b0}};
        case (state_r)
            ST_TRIG_HI: begin
                if (fall_s && width_ok_s) begin
                    tmr_load_s = 1'b1;
                    tmr_val_s  = BURST_LD;
                end else begin
                    tmr_load_s = 1'b0;
                end
            end
            ST_BURST: begin
                if (tmr_zero_s) begin
                    tmr_load_s = 1'b1;
                    // A zero-length echo skips straight to hold-off.
                    tmr_val_s  = (len_r != {CW{1'b0}}) ? (len_r - ONE) : HOLD_LD;
                end else begin
                    tmr_load_s = 1'b0;
                end
            end
            ST_ECHO: begin
                if (tmr_zero_s) begin
                    tmr_load_s = 1'b1;
                    tmr_val_s  = HOLD_LD;
                end else begin
                    tmr_load_s = 1'b0;
                end
            end
            default: begin
                tmr_load_s = 1'b0;
            end
        endcase
    end

    sonar_cycle_timer #(.CW(CW)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load_s),
        .load_val (tmr_val_s),
        .zero     (tmr_zero_s)
    );

    // Measurement FSM with registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            trig_q_r     <= 1'b1;   // a trig already high at release is not an edge
            width_r      <= {CW{1'b0}};
            len_r        <= {CW{1'b0}};
            echo_r       <= 1'b0;
            busy_r       <= 1'b0;
            trig_short_r <= 1'b0;
            done_r       <= 1'b0;
        end else begin
            trig_q_r     <= trig;
            trig_short_r <= 1'b0;
            done_r       <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (rise_s) begin
                        state_r <= ST_TRIG_HI;
                        width_r <= ONE;
                        busy_r  <= 1'b1;
                    end else begin
                        busy_r  <= 1'b0;
                    end
                end
                ST_TRIG_HI: begin
                    if (fall_s) begin
                        if (width_ok_s) begin
                            len_r   <= len_s;
                            state_r <= ST_BURST;
                        end else begin
                            trig_short_r <= 1'b1;
                            busy_r       <= 1'b0;
                            state_r      <= ST_IDLE;
                        end
                    end else if (width_r < MIN_C) begin
                        width_r <= width_r + ONE;
                    end else begin
                        width_r <= width_r;
                    end
                end
                ST_BURST: begin
                    if (tmr_zero_s) begin
                        if (len_r != {CW{1'b0}}) begin
                            echo_r  <= 1'b1;
                            state_r <= ST_ECHO;
                        end else begin
                            done_r  <= 1'b1;
                            state_r <= ST_HOLDOFF;
                        end
                    end else begin
                        state_r <= ST_BURST;
                    end
                end
                ST_ECHO: begin
                    if (tmr_zero_s) begin
                        echo_r  <= 1'b0;
                        done_r  <= 1'b1;
                        state_r <= ST_HOLDOFF;
                    end else begin
                        state_r <= ST_ECHO;
                    end
                end
                ST_HOLDOFF: begin
                    if (tmr_zero_s) begin
                        busy_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_HOLDOFF;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    echo_r  <= 1'b0;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign echo       = echo_r;
    assign busy       = busy_r;
    assign trig_short = trig_short_r;
    assign done       = done_r;

endmodule

// File: doc/sonar_echo_emulator.md
Name: sonar_echo_emulator

Overview:
Synthesizable model of the ultrasonic sensor (the responder) that answers trigger pulses from the sonar controller with an echo pulse of programmable width.
- Used for closed-loop FPGA self-test and simulation of the ranging path without a physical sensor.
- Checks trigger width, models the transmit-burst delay, drives echo for the programmed time-of-flight (or the no-object timeout), then enforces a re-trigger hold-off.

Parameters:
- MIN_TRIG_CYC, 1000: minimum valid trigger high time in clk cycles (10 us at 100 MHz).
- BURST_CYC, 20000: delay from trigger fall to echo rise (models the 8-cycle 40 kHz burst).
- TIMEOUT_CYC, 3800000: echo width when no object is present (38 ms).
- HOLDOFF_CYC, 6000000: dead time after echo fall; triggers are ignored during it.
- CW, 24: internal counter width; must hold max(TIMEOUT_CYC, HOLDOFF_CYC, BURST_CYC).

Ports:
- clk  in  1  system clock, 100 MHz nominal
- rst_n  in  1  asynchronous active-low reset
- trig  in  1  trigger from the sonar controller, synchronous to clk
- echo_len  in  16  echo high time in clk cycles when an object is present
- obj_present  in  1  1 = object in range (use echo_len), 0 = timeout echo
- echo  out  1  echo pulse to the controller
- busy  out  1  high in every state except IDLE
- trig_short  out  1  one-cycle pulse when a trigger shorter than MIN_TRIG_CYC is rejected
- done  out  1  one-cycle pulse on the cycle echo falls (or would have fallen)

Behaviour:
- One clock; reset is asynchronous and active-low. Clock port clk, reset port rst_n.
- Reset values: echo=0, busy=0, trig_short=0, done=0, state=IDLE, counters=0, trig_q=1.
  - Because trig_q resets to 1, a trig already held high at reset release is not a rising edge.
- All outputs are registered. Reset asserted mid-operation aborts immediately to the reset values; there is no partial echo completion.
- States: IDLE, TRIG_HI, BURST, ECHO, HOLDOFF.
- IDLE: on rising edge (trig=1, trig_q=0), go to TRIG_HI with width counter=1.
- TRIG_HI:
  - While trig=1, the width counter increments, saturating at MIN_TRIG_CYC. trig held high indefinitely keeps the block in TRIG_HI.
  - On falling edge (trig=0, trig_q=1), call that posedge t0:
    - If width >= MIN_TRIG_CYC: latch echo_len and obj_present, then go to BURST.
    - Else: pulse trig_short for 1 cycle and return to IDLE.
- BURST:
  - Counts BURST_CYC cycles.
  - echo goes high in the cycle following posedge t0+BURST_CYC, then go to ECHO.
- ECHO:
  - echo stays high for exactly L cycles.
  - L = latched echo_len if obj_present was latched 1; otherwise L = TIMEOUT_CYC.
  - L is clamped to TIMEOUT_CYC.
  - When echo falls, pulse done and go to HOLDOFF.
- echo_len=0 with object present: echo never rises. done pulses in the cycle echo would have risen, then go to HOLDOFF.
- HOLDOFF: counts HOLDOFF_CYC cycles, then returns to IDLE. trig_q keeps tracking trig, so a trig still high on entering IDLE is not a new edge.
- Trigger activity in BURST, ECHO or HOLDOFF is ignored: no restart and no trig_short.
- echo_len and obj_present are sampled only at t0; changes afterwards have no effect on the current measurement.
- Counter arithmetic is unsigned CW-bit. Down-counters load value-1 and finish at 0, so no counter ever wraps.

Decomposition:
- Package sonar_pkg holds:
  - the state encoding (IDLE..HOLDOFF);
  - default timing constants (10 us trigger, 200 us burst, 38 ms timeout, 60 ms hold-off at 100 MHz), shared with the sonar controller and its bench.
- Sub-module sonar_cycle_timer: a CW-bit load/decrement timer with a zero flag. It is reused for the BURST, ECHO and HOLDOFF intervals. The width counter stays local.

Test Plan:
Simulation overrides for all scenarios: BURST_CYC=100, TIMEOUT_CYC=5000, HOLDOFF_CYC=200.
1. trig high 1000 cycles, echo_len=500, obj_present=1 -> echo rises 100 cycles after trig fall and stays high exactly 500 cycles; done pulses once; busy drops 200 cycles after echo fall.
2. trig high 999 cycles -> trig_short pulses once; echo stays 0; back in IDLE with busy=0 the next cycle.
3. obj_present=0, valid 1000-cycle trigger -> echo high exactly 5000 cycles, then done.
4. Second trigger issued during ECHO and again during HOLDOFF -> ignored. A trigger issued after busy falls produces a normal echo.
5. rst_n asserted midway through a 500-cycle echo -> echo=0 and busy=0 immediately; trig held high through reset release produces no response until trig toggles.
6. echo_len=0, obj_present=1 -> echo never rises; done pulses at the 100-cycle mark; the block returns to IDLE after hold-off.
